interrupt_sequencer: RTL and testbench

Upstream control stage of the 65C02 program counter. It arbitrates reset, NMI, IRQ and BRK, then runs the 5-step interrupt sequence:

- push PCH, push PCL, push P;
- fetch the vector low byte, then the vector high byte.

It drives the `push_resb` / `push_nmib` / `push_irqb` select strobes that load the vector address into the PC low-byte register. It also stalls the instruction decoder for the duration of the sequence.

---
 rtl/interrupt_sequencer.sv | 137 +++++++++++++
 tb/tb_interrupt_sequencer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/interrupt_sequencer.sv
// Interrupt sequencer for the 65C02 PC path: arbitrates RST/NMI/IRQ/BRK and
// steps through the push-PCH/PCL/P, vector-low/high sequence.
module interrupt_sequencer (
  input  logic       fclk,
  input  logic       resb,
  input  logic       nmib,
  input  logic       irqb,
  input  logic       i_flag,
  input  logic       instr_boundary,
  input  logic       brk_exec,
  input  logic       rdy,
  output logic       seq_active,
  output logic [1:0] stack_op,
  output logic       stack_write_en,
  output logic       b_flag,
  output logic       push_resb,
  output logic       push_nmib,
  output logic       push_irqb,
  output logic       vec_lo_load,
  output logic       vec_hi_load,
  output logic       set_i,
  output logic       clear_d,
  output logic       nmi_pending
);

  typedef enum logic [2:0] {
    RST_HOLD, IDLE, STK_H, STK_L, STK_P, VEC_L, VEC_H
  } state_t;

  typedef enum logic [1:0] {T_RST, T_NMI, T_IRQ, T_BRK} req_t;

  state_t state;
  req_t   req;
  logic   nmi_s1, nmi_s2, nmi_prev;
  logic   irq_s1, irq_s2;
  logic   nmi_edge, adv, nmi_clr;

  assign nmi_edge = nmi_prev & ~nmi_s2;
  // Strobes only fire on an advancing cycle; resb low suppresses them at once.
  assign adv      = rdy & resb;
  assign nmi_clr  = (state == STK_P) && adv && (req == T_NMI);

  always_ff @(posedge fclk) begin
    if (!resb) begin
      state       <= RST_HOLD;
      req         <= T_RST;
      nmi_s1      <= 1'b1;
      nmi_s2      <= 1'b1;
      nmi_prev    <= 1'b1;
      irq_s1      <= 1'b1;
      irq_s2      <= 1'b1;
      nmi_pending <= 1'b0;
    end else begin
      nmi_s1   <= nmib;
      nmi_s2   <= nmi_s1;
      nmi_prev <= nmi_s2;
      irq_s1   <= irqb;
      irq_s2   <= irq_s1;
      // A fresh edge on the clearing cycle must not be lost.
      if (nmi_edge)     nmi_pending <= 1'b1;
      else if (nmi_clr) nmi_pending <= 1'b0;

      case (state)
        RST_HOLD: begin
          state <= STK_H;
          req   <= T_RST;
        end
        IDLE: begin
          if (brk_exec) begin
            state <= STK_H;
            req   <= T_BRK;
          end else if (instr_boundary && nmi_pending) begin
            state <= STK_H;
            req   <= T_NMI;
          end else if (instr_boundary && !irq_s2 && !i_flag) begin
            state <= STK_H;
            req   <= T_IRQ;
          end
        end
        STK_H:   if (rdy) state <= STK_L;
        STK_L:   if (rdy) state <= STK_P;
        STK_P:   if (rdy) state <= VEC_L;
        VEC_L:   if (rdy) state <= VEC_H;
        VEC_H:   if (rdy) state <= IDLE;
        default: state <= RST_HOLD;
      endcase
    end
  end

  // Outputs are a pure decode of the registered state/type, qualified by adv.
  always_comb begin
    seq_active     = 1'b0;
    stack_op       = 2'b00;
    stack_write_en = 1'b0;
    b_flag         = 1'b0;
    push_resb      = 1'b0;
    push_nmib      = 1'b0;
    push_irqb      = 1'b0;
    vec_lo_load    = 1'b0;
    vec_hi_load    = 1'b0;
    set_i          = 1'b0;
    clear_d        = 1'b0;
    case (state)
      STK_H: begin
        seq_active     = 1'b1;
        stack_op       = 2'b01;
        stack_write_en = (req != T_RST);
      end
      STK_L: begin
        seq_active     = 1'b1;
        stack_op       = 2'b10;
        stack_write_en = (req != T_RST);
      end
      STK_P: begin
        seq_active     = 1'b1;
        stack_op       = 2'b11;
        stack_write_en = (req != T_RST);
        b_flag         = (req == T_BRK);
        push_resb      = adv && (req == T_RST);
        push_nmib      = adv && (req == T_NMI);
        push_irqb      = adv && ((req == T_IRQ) || (req == T_BRK));
      end
      VEC_L: begin
        seq_active  = 1'b1;
        vec_lo_load = adv;
        set_i       = adv;
        clear_d     = adv;
      end
      VEC_H: begin
        seq_active  = 1'b1;
        vec_hi_load = adv;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer: reset, IRQ mask, BRK, NMI priority,
// rdy stall and mid-sequence reset, with hand-written expected output words.
module tb_interrupt_sequencer;
  logic fclk = 1'b0;
  logic resb = 1'b0, nmib = 1'b1, irqb = 1'b1, i_flag = 1'b1;
  logic instr_boundary = 1'b0, brk_exec = 1'b0, rdy = 1'b1;
  logic seq_active, stack_write_en, b_flag, push_resb, push_nmib, push_irqb;
  logic vec_lo_load, vec_hi_load, set_i, clear_d, nmi_pending;
  logic [1:0] stack_op;
  logic [11:0] obs;

  int errors = 0;
  int checks = 0;

  interrupt_sequencer dut (
    .fclk(fclk), .resb(resb), .nmib(nmib), .irqb(irqb), .i_flag(i_flag),
    .instr_boundary(instr_boundary), .brk_exec(brk_exec), .rdy(rdy),
    .seq_active(seq_active), .stack_op(stack_op), .stack_write_en(stack_write_en),
    .b_flag(b_flag), .push_resb(push_resb), .push_nmib(push_nmib),
    .push_irqb(push_irqb), .vec_lo_load(vec_lo_load), .vec_hi_load(vec_hi_load),
    .set_i(set_i), .clear_d(clear_d), .nmi_pending(nmi_pending)
  );

  always #5 fclk = ~fclk;

  // {seq, op[1:0], we, b, presb, pnmib, pirqb, vlo, vhi, set_i, clear_d}
  assign obs = {seq_active, stack_op, stack_write_en, b_flag, push_resb,
                push_nmib, push_irqb, vec_lo_load, vec_hi_load, set_i, clear_d};

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge fclk);
    #1;
  endtask

  // Entered just after the acceptance edge; walks the 5 steps then checks IDLE.
  task automatic check_seq(input string tag, input logic w, input logic b,
                           input logic pr, input logic pn, input logic pi,
                           input logic [4:0] np, input int fall_at);
    logic [11:0] e [5];
    e[0] = {1'b1, 2'b01, w, 1'b0, 7'b0};
    e[1] = {1'b1, 2'b10, w, 1'b0, 7'b0};
    e[2] = {1'b1, 2'b11, w, b, pr, pn, pi, 4'b0};
    e[3] = 12'h80B;
    e[4] = 12'h804;
    for (int i = 0; i < 5; i++) begin
      if (fall_at >= 0 && i == 0) nmib = 1'b1;
      if (i == fall_at) nmib = 1'b0;
      #1;
      chk($sformatf("%s step%0d", tag, i), obs, e[i]);
      chk($sformatf("%s np%0d", tag, i), {11'b0, nmi_pending}, {11'b0, np[i]});
      tick;
    end
    #1;
    chk($sformatf("%s idle", tag), obs, 12'h000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and reset sequence
    repeat (3) tick;
    chk("rst hold", obs, 12'h000);
    chk("rst np", {11'b0, nmi_pending}, 12'h000);
    resb = 1'b1;
    tick;
    check_seq("rst", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'b00000, -1);

    // IRQ masked by i_flag
    irqb = 1'b0;
    repeat (3) tick;
    instr_boundary = 1'b1;
    tick;
    instr_boundary = 1'b0;
    #1;
    chk("irq masked", obs, 12'h000);
    i_flag = 1'b0;
    instr_boundary = 1'b1;
    tick;
    instr_boundary = 1'b0;
    irqb = 1'b1;
    check_seq("irq", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'b00000, -1);
    i_flag = 1'b1;

    // BRK
    brk_exec = 1'b1;
    tick;
    brk_exec = 1'b0;
    check_seq("brk", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'b00000, -1);

    // NMI beats IRQ; second NMI edge arrives during VEC_L
    irqb = 1'b0;
    i_flag = 1'b0;
    nmib = 1'b0;
    repeat (3) tick;
    chk("nmi latency", {11'b0, nmi_pending}, 12'h001);
    instr_boundary = 1'b1;
    tick;
    instr_boundary = 1'b0;
    check_seq("nmi", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00111, 3);
    i_flag = 1'b1;
    irqb = 1'b1;
    chk("nmi2 not yet", {11'b0, nmi_pending}, 12'h000);
    tick;
    chk("nmi2 pending", {11'b0, nmi_pending}, 12'h001);
    chk("nmi2 idle", obs, 12'h000);
    instr_boundary = 1'b1;
    tick;
    instr_boundary = 1'b0;
    check_seq("nmi2", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00111, -1);

    // rdy stall in STK_L: 9-cycle sequence
    brk_exec = 1'b1;
    tick;
    brk_exec = 1'b0;
    #1 chk("stall stk_h", obs, 12'hB00);
    tick;
    rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 chk($sformatf("stall hold%0d", i), obs, 12'hD00);
      tick;
    end
    rdy = 1'b1;
    #1 chk("stall resume", obs, 12'hD00);
    tick;
    #1 chk("stall stk_p", obs, 12'hF90);
    tick;
    #1 chk("stall vec_l", obs, 12'h80B);
    tick;
    #1 chk("stall vec_h", obs, 12'h804);
    tick;
    #1 chk("stall idle", obs, 12'h000);

    // Reset during VEC_L with NMI pending
    nmib = 1'b1;
    repeat (3) tick;
    nmib = 1'b0;
    repeat (3) tick;
    chk("mid np set", {11'b0, nmi_pending}, 12'h001);
    brk_exec = 1'b1;
    tick;
    brk_exec = 1'b0;
    repeat (3) tick;
    resb = 1'b0;
    nmib = 1'b1;
    #1 chk("mid vl gated", obs, 12'h800);
    tick;
    chk("mid rst_hold", obs, 12'h000);
    chk("mid np clr", {11'b0, nmi_pending}, 12'h000);
    resb = 1'b1;
    tick;
    check_seq("rst2", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'b00000, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
